// File: rtl/axis_fsb_bridge.sv
// Bridge between a 128-bit AXI-Stream host port and an 80-bit FSB port.
// Each direction is an independent FIFO; malformed host beats are dropped and counted.

module axis_fsb_bridge_fifo #(
  parameter int W     = 80,
  parameter int ELS_P = 4
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         enq_i,
  input  logic [W-1:0] data_i,
  input  logic         deq_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] data_o
);
  localparam int AW = $clog2(ELS_P);
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] mem_q [ELS_P];
  logic [AW:0]  wptr_q, wptr_d;
  logic [AW:0]  rptr_q, rptr_d;

  // Wrap bit distinguishes full from empty when the index bits match.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW-1:0] == rptr_q[AW-1:0])
                 & (wptr_q[AW] != rptr_q[AW]);
  assign data_o  = mem_q[rptr_q[AW-1:0]];

  assign wptr_d = enq_i ? wptr_q + ONE : wptr_q;
  assign rptr_d = deq_i ? rptr_q + ONE : rptr_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq_i) mem_q[wptr_q[AW-1:0]] <= data_i;
  end
endmodule

module axis_fsb_bridge #(
  parameter int ELS_P = 4
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         s_axis_tvalid_i,
  output logic         s_axis_tready_o,
  input  logic [127:0] s_axis_tdata_i,
  input  logic [15:0]  s_axis_tkeep_i,
  input  logic         s_axis_tlast_i,
  output logic         fsb_v_o,
  output logic [79:0]  fsb_data_o,
  input  logic         fsb_ready_i,
  input  logic         fsb_v_i,
  input  logic [79:0]  fsb_data_i,
  output logic         fsb_ready_o,
  output logic         m_axis_tvalid_o,
  input  logic         m_axis_tready_i,
  output logic [127:0] m_axis_tdata_o,
  output logic [15:0]  m_axis_tkeep_o,
  output logic         m_axis_tlast_o,
  output logic [15:0]  drop_count_o,
  output logic [31:0]  rx_count_o,
  output logic [31:0]  tx_count_o
);
  logic        h_full, h_empty, u_full, u_empty;
  logic [79:0] u_head;
  logic        s_acc, keep_ok, h_enq, h_deq, drop;
  logic        u_enq, u_deq;
  logic [15:0] drop_q, drop_d;
  logic [31:0] rx_q, rx_d, tx_q, tx_d;
  logic        unused_bits;

  assign unused_bits = ^{s_axis_tdata_i[127:80],
                         s_axis_tkeep_i[15:10],
                         s_axis_tlast_i};

  assign s_axis_tready_o = ~reset_i & ~h_full;
  assign s_acc   = s_axis_tvalid_i & s_axis_tready_o;
  assign keep_ok = (s_axis_tkeep_i[9:0] == 10'h3FF);
  assign h_enq   = s_acc & keep_ok;
  assign drop    = s_acc & ~keep_ok;

  assign fsb_v_o = ~reset_i & ~h_empty;
  assign h_deq   = fsb_v_o & fsb_ready_i;

  assign fsb_ready_o = ~reset_i & ~u_full;
  assign u_enq       = fsb_v_i & fsb_ready_o;

  assign m_axis_tvalid_o = ~reset_i & ~u_empty;
  assign u_deq           = m_axis_tvalid_o & m_axis_tready_i;
  assign m_axis_tdata_o  = {48'h0, u_head};
  assign m_axis_tkeep_o  = 16'h03FF;
  assign m_axis_tlast_o  = 1'b1;

  axis_fsb_bridge_fifo #(.W(80), .ELS_P(ELS_P)) u_h2f (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .enq_i   (h_enq),
    .data_i  (s_axis_tdata_i[79:0]),
    .deq_i   (h_deq),
    .full_o  (h_full),
    .empty_o (h_empty),
    .data_o  (fsb_data_o)
  );

  axis_fsb_bridge_fifo #(.W(80), .ELS_P(ELS_P)) u_f2h (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .enq_i   (u_enq),
    .data_i  (fsb_data_i),
    .deq_i   (u_deq),
    .full_o  (u_full),
    .empty_o (u_empty),
    .data_o  (u_head)
  );

  // Drop counter sticks at all-ones instead of wrapping.
  assign drop_d = (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
  assign rx_d   = h_deq ? rx_q + 32'd1 : rx_q;
  assign tx_d   = u_deq ? tx_q + 32'd1 : tx_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      drop_q <= '0;
      rx_q   <= '0;
      tx_q   <= '0;
    end else begin
      drop_q <= drop_d;
      rx_q   <= rx_d;
      tx_q   <= tx_d;
    end
  end

  assign drop_count_o = drop_q;
  assign rx_count_o   = rx_q;
  assign tx_count_o   = tx_q;
endmodule

// File: tb/tb_axis_fsb_bridge.sv
// Scoreboard bench for axis_fsb_bridge: drivers push expected packets,
// negedge monitors pop and compare whenever an output is valid.

module tb_axis_fsb_bridge;
  logic         clk = 1'b0;
  logic         reset_i = 1'b1;
  logic         s_tvalid = 1'b0;
  logic         s_tready;
  logic [127:0] s_tdata = '0;
  logic [15:0]  s_tkeep = '0;
  logic         s_tlast = 1'b0;
  logic         fsb_v_o;
  logic [79:0]  fsb_data_o;
  logic         fsb_ready_i = 1'b0;
  logic         fsb_v_i = 1'b0;
  logic [79:0]  fsb_data_i = '0;
  logic         fsb_ready_o;
  logic         m_tvalid;
  logic         m_tready = 1'b0;
  logic [127:0] m_tdata;
  logic [15:0]  m_tkeep;
  logic         m_tlast;
  logic [15:0]  drop_cnt;
  logic [31:0]  rx_cnt, tx_cnt;

  axis_fsb_bridge #(.ELS_P(4)) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .s_axis_tvalid_i (s_tvalid),
    .s_axis_tready_o (s_tready),
    .s_axis_tdata_i  (s_tdata),
    .s_axis_tkeep_i  (s_tkeep),
    .s_axis_tlast_i  (s_tlast),
    .fsb_v_o         (fsb_v_o),
    .fsb_data_o      (fsb_data_o),
    .fsb_ready_i     (fsb_ready_i),
    .fsb_v_i         (fsb_v_i),
    .fsb_data_i      (fsb_data_i),
    .fsb_ready_o     (fsb_ready_o),
    .m_axis_tvalid_o (m_tvalid),
    .m_axis_tready_i (m_tready),
    .m_axis_tdata_o  (m_tdata),
    .m_axis_tkeep_o  (m_tkeep),
    .m_axis_tlast_o  (m_tlast),
    .drop_count_o    (drop_cnt),
    .rx_count_o      (rx_cnt),
    .tx_count_o      (tx_cnt)
  );

  always #5 clk = ~clk;

  logic [79:0] exp_f[$];
  logic [79:0] exp_m[$];
  int pass_cnt = 0;
  int tot_cnt  = 0;
  int exp_rx   = 0;
  int exp_tx   = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%h required=%h", nm, act, exp);
  endtask

  task automatic fail(input string nm);
    tot_cnt++;
    $display("FAIL %s", nm);
  endtask

  // Monitors: every valid cycle must show the scoreboard head.
  always @(negedge clk) begin
    if (fsb_v_o) begin
      if (exp_f.size() == 0) fail("fsb_unexpected_packet");
      else begin
        chk("fsb_data", {48'h0, fsb_data_o}, {48'h0, exp_f[0]});
        if (fsb_ready_i) begin
          void'(exp_f.pop_front());
          exp_rx++;
        end
      end
    end
    if (m_tvalid) begin
      if (exp_m.size() == 0) fail("m_axis_unexpected_beat");
      else begin
        chk("m_tdata", m_tdata, {48'h0, exp_m[0]});
        if (m_tready) begin
          chk("m_tkeep", {112'h0, m_tkeep}, 128'h03FF);
          chk("m_tlast", {127'h0, m_tlast}, 128'h1);
          void'(exp_m.pop_front());
          exp_tx++;
        end
      end
    end
  end

  task automatic send_host(input logic [127:0] d, input logic [15:0] k,
                           input bit good);
    bit done = 0;
    s_tdata  = d;
    s_tkeep  = k;
    s_tvalid = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (s_tready) begin
        if (good) exp_f.push_back(d[79:0]);
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) fail("host_send_timeout");
    s_tvalid = 1'b0;
  endtask

  task automatic send_fsb(input logic [79:0] d);
    bit done = 0;
    fsb_data_i = d;
    fsb_v_i    = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (fsb_ready_o) begin
        exp_m.push_back(d);
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) fail("fsb_send_timeout");
    fsb_v_i = 1'b0;
  endtask

  task automatic drain;
    int t = 0;
    while ((exp_f.size() != 0 || exp_m.size() != 0) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) fail("drain_timeout");
    @(posedge clk); #1;
  endtask

  initial begin
    int acc;
    bit last_rdy;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_tready", {127'h0, s_tready}, 128'h0);
    chk("rst_fsb_ready", {127'h0, fsb_ready_o}, 128'h0);
    chk("rst_fsb_v", {127'h0, fsb_v_o}, 128'h0);
    chk("rst_m_tvalid", {127'h0, m_tvalid}, 128'h0);
    chk("rst_counts", {rx_cnt, tx_cnt, 16'h0, drop_cnt}, 128'h0);
    @(posedge clk); #1;
    reset_i = 1'b0;
    @(negedge clk);
    chk("post_rst_s_tready", {127'h0, s_tready}, 128'h1);
    chk("post_rst_fsb_ready", {127'h0, fsb_ready_o}, 128'h1);
    @(posedge clk); #1;

    // Single beat, one-cycle latency, no bypass
    fsb_ready_i = 1'b1;
    s_tdata  = 128'h0000_0000_0000_1234_5678_9ABC_DEF0_1122;
    s_tkeep  = 16'hFFFF;
    s_tvalid = 1'b1;
    @(negedge clk);
    chk("single_accept", {127'h0, s_tready}, 128'h1);
    chk("single_no_bypass", {127'h0, fsb_v_o}, 128'h0);
    exp_f.push_back(80'h1234_5678_9ABC_DEF0_1122);
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    @(negedge clk);
    chk("single_next_cycle_v", {127'h0, fsb_v_o}, 128'h1);
    @(posedge clk); #1;
    chk("single_rx_count", {96'h0, rx_cnt}, 128'd1);

    // Backpressure until full, then drain in order
    fsb_ready_i = 1'b0;
    acc = 0;
    last_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_tdata  = {48'hFFFF_FFFF_FFFF, 80'h5000 + 80'(i)};
      s_tkeep  = 16'hFFFF;
      s_tvalid = 1'b1;
      @(negedge clk);
      last_rdy = s_tready;
      if (s_tready) begin
        exp_f.push_back(80'h5000 + 80'(i));
        acc++;
      end
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
    chk("full_accepted", 128'(acc), 128'd4);
    chk("full_5th_tready", {127'h0, last_rdy}, 128'h0);
    fsb_ready_i = 1'b1;
    drain();
    chk("full_rx_count", {96'h0, rx_cnt}, 128'(exp_rx));

    // Drop path and keep boundary
    send_host(128'h0000_0000_0000_0000_0000_0000_0000_00BB, 16'h01FF, 0);
    @(negedge clk);
    chk("drop_one", {112'h0, drop_cnt}, 128'd1);
    chk("drop_no_v", {127'h0, fsb_v_o}, 128'h0);
    @(posedge clk); #1;
    send_host(128'hABCD_EF01_2345_0000_0000_0000_0000_CAFE, 16'h03FF, 1);
    send_host(128'h0000_0000_0000_0000_0000_0000_0000_0077, 16'hFDFF, 0);
    drain();
    chk("drop_two", {112'h0, drop_cnt}, 128'd2);
    s_tkeep  = 16'h01FF;
    s_tvalid = 1'b1;
    repeat (65538) @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    @(negedge clk);
    chk("drop_saturate", {112'h0, drop_cnt}, 128'hFFFF);
    chk("drop_rx_count", {96'h0, rx_cnt}, 128'(exp_rx));
    @(posedge clk); #1;

    // Upstream with toggling ready and holding
    m_tready = 1'b0;
    send_fsb(80'hA5);
    for (int i = 0; i < 6; i++) begin
      m_tready = (i % 3 == 2);
      @(posedge clk); #1;
    end
    m_tready = 1'b0;
    chk("up_tx_count", {96'h0, tx_cnt}, 128'd1);
    for (int i = 0; i < 4; i++) send_fsb(80'hB000 + 80'(i));
    fsb_data_i = 80'hBEEF;
    fsb_v_i = 1'b1;
    @(negedge clk);
    chk("up_full_ready", {127'h0, fsb_ready_o}, 128'h0);
    @(posedge clk); #1;
    fsb_v_i = 1'b0;
    m_tready = 1'b1;
    drain();
    chk("up_tx_total", {96'h0, tx_cnt}, 128'(exp_tx));

    // Simultaneous enqueue/dequeue at occupancy 2
    fsb_ready_i = 1'b0;
    send_host({48'h0, 80'hC000}, 16'h03FF, 1);
    send_host({48'h0, 80'hC001}, 16'h03FF, 1);
    fsb_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_tdata  = {48'h0, 80'hD000 + 80'(i)};
      s_tkeep  = 16'hFFFF;
      s_tvalid = 1'b1;
      @(negedge clk);
      if (i == 9) chk("simul_tready", {127'h0, s_tready}, 128'h1);
      if (s_tready) exp_f.push_back(80'hD000 + 80'(i));
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
    fsb_ready_i = 1'b0;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      s_tdata  = {48'h0, 80'hE000 + 80'(i)};
      s_tvalid = 1'b1;
      @(negedge clk);
      if (s_tready) begin
        exp_f.push_back(80'hE000 + 80'(i));
        acc++;
      end
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
    chk("simul_occupancy", 128'(acc), 128'd2);
    fsb_ready_i = 1'b1;
    drain();
    chk("simul_rx_count", {96'h0, rx_cnt}, 128'(exp_rx));

    // Reset mid-flight
    fsb_ready_i = 1'b0;
    m_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_host({48'h0, 80'hF000 + 80'(i)}, 16'hFFFF, 1);
      send_fsb(80'hF100 + 80'(i));
    end
    reset_i = 1'b1;
    @(negedge clk);
    chk("midrst_valids", {126'h0, fsb_v_o, m_tvalid}, 128'h0);
    chk("midrst_readies", {126'h0, s_tready, fsb_ready_o}, 128'h0);
    exp_f.delete();
    exp_m.delete();
    @(posedge clk); #1;
    reset_i = 1'b0;
    @(negedge clk);
    chk("midrst_counts", {rx_cnt, tx_cnt, 16'h0, drop_cnt}, 128'h0);
    chk("midrst_readies_up", {126'h0, s_tready, fsb_ready_o}, 128'h3);
    chk("midrst_valids_low", {126'h0, fsb_v_o, m_tvalid}, 128'h0);
    @(posedge clk); #1;
    fsb_ready_i = 1'b1;
    m_tready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("midrst_no_stale", {126'h0, fsb_v_o, m_tvalid}, 128'h0);
    chk("midrst_counts_idle", {rx_cnt, tx_cnt, 16'h0, drop_cnt}, 128'h0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/axis_fsb_bridge.md
AXIS_FSB_BRIDGE -- requirements
Module: axis_fsb_bridge

Interface
REQ-001 SHALL have parameter ELS_P, default 4: entries in each direction FIFO; power of two, >= 2.
REQ-002 SHALL have port clk_i  in  1  the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port reset_i  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port s_axis_tvalid_i  in  1  host-to-FSB stream beat valid.
REQ-005 SHALL have port s_axis_tready_o  out  1  host-to-FSB stream ready.
REQ-006 SHALL have port s_axis_tdata_i  in  128  host-to-FSB beat data; bits [79:0] carry one FSB packet.
REQ-007 SHALL have port s_axis_tkeep_i  in  16  host-to-FSB byte keep.
REQ-008 SHALL have port s_axis_tlast_i  in  1  host-to-FSB last; ignored.
REQ-009 SHALL have port fsb_v_o  out  1  FSB master packet valid.
REQ-010 SHALL have port fsb_data_o  out  80  FSB master packet.
REQ-011 SHALL have port fsb_ready_i  in  1  FSB master ready.
REQ-012 SHALL have port fsb_v_i  in  1  FSB slave packet valid.
REQ-013 SHALL have port fsb_data_i  in  80  FSB slave packet.
REQ-014 SHALL have port fsb_ready_o  out  1  FSB slave ready.
REQ-015 SHALL have port m_axis_tvalid_o  out  1  FSB-to-host stream beat valid.
REQ-016 SHALL have port m_axis_tready_i  in  1  FSB-to-host stream ready.
REQ-017 SHALL have port m_axis_tdata_o  out  128  FSB-to-host beat data.
REQ-018 SHALL have port m_axis_tkeep_o  out  16  FSB-to-host byte keep.
REQ-019 SHALL have port m_axis_tlast_o  out  1  FSB-to-host last.
REQ-020 SHALL have port drop_count_o  out  16  count of rejected host beats.
REQ-021 SHALL have port rx_count_o  out  32  count of packets delivered on fsb_*_o.
REQ-022 SHALL have port tx_count_o  out  32  count of beats delivered on m_axis_*.

Function
REQ-023 SHALL accept a host beat when s_axis_tvalid_i & s_axis_tready_o; s_axis_tready_o = host-to-FSB FIFO not full.
REQ-024 SHALL enqueue s_axis_tdata_i[79:0] on an accepted beat iff s_axis_tkeep_i[9:0] == 10'h3FF; bits [127:80] and tkeep[15:10] SHALL be ignored.
REQ-025 SHALL drop an accepted beat with tkeep[9:0] != 10'h3FF and increment drop_count_o, saturating at 16'hFFFF.
REQ-026 SHALL drive fsb_v_o = host-to-FSB FIFO not empty and fsb_data_o = FIFO head; the packet is dequeued on fsb_v_o & fsb_ready_i.
REQ-027 SHALL have no bypass: an enqueued packet appears on fsb_v_o exactly one cycle after acceptance, earliest.
REQ-028 SHALL hold s_axis_tready_o low when full, even if a dequeue happens in the same cycle; when not full, simultaneous enqueue and dequeue SHALL leave occupancy unchanged.
REQ-029 SHALL accept an FSB packet when fsb_v_i & fsb_ready_o; fsb_ready_o = FSB-to-host FIFO not full, with the same full and simultaneous-operation rules as REQ-028.
REQ-030 SHALL drive m_axis_tvalid_o = FSB-to-host FIFO not empty, m_axis_tdata_o = {48'h0, head}, m_axis_tkeep_o = 16'h03FF, m_axis_tlast_o = 1.
REQ-031 SHALL keep m_axis_tdata_o stable while m_axis_tvalid_o & ~m_axis_tready_i; the beat is dequeued on m_axis_tvalid_o & m_axis_tready_i.
REQ-032 SHALL keep fsb_data_o stable while fsb_v_o & ~fsb_ready_i.
REQ-033 SHALL increment rx_count_o on each fsb_v_o & fsb_ready_i and tx_count_o on each m_axis handshake; both SHALL wrap modulo 2^32.
REQ-034 SHALL use read/write pointers of log2(ELS_P) bits plus a wrap bit per FIFO: empty when pointers are equal including wrap bit; full when pointers are equal and wrap bits differ.
REQ-035 SHALL keep the two directions fully independent; no ordering between them.

Reset
REQ-036 SHALL, while reset_i is high, empty both FIFOs and zero drop_count_o, rx_count_o and tx_count_o.
REQ-037 SHALL drive s_axis_tready_o = 0, fsb_ready_o = 0, fsb_v_o = 0 and m_axis_tvalid_o = 0 while reset_i is high.
REQ-038 SHALL, when reset is asserted mid-transfer, discard all buffered packets; none reappear after reset.
REQ-039 SHALL assert both readies in the first cycle after reset_i falls.

Verification
REQ-040 Single beat: host beat data=128'h...0000_1234_5678_9ABC_DEF0_1122, tkeep=16'hFFFF, fsb_ready_i=1 -> next cycle fsb_v_o=1, fsb_data_o=80'h1234_5678_9ABC_DEF0_1122, rx_count_o=1.
REQ-041 Backpressure/full: fsb_ready_i=0, 5 valid beats with ELS_P=4 -> 4 accepted, s_axis_tready_o=0 on the 5th cycle; raising fsb_ready_i drains 4 packets in order.
REQ-042 Drop: beat with tkeep=16'h01FF -> no fsb_v_o, drop_count_o=1; 65540 such beats -> drop_count_o=16'hFFFF.
REQ-043 Upstream: fsb_data_i=80'hA5 with fsb_v_i=1 and m_axis_tready_i toggling -> m_axis_tdata_o=128'hA5, tkeep=16'h03FF, tlast=1, stable until accepted, tx_count_o=1.
REQ-044 Simultaneous: FIFO holding 2 entries, enqueue and dequeue in the same cycle for 10 cycles -> occupancy stays 2 and order is preserved.
REQ-045 Reset mid-flight: 3 packets buffered each way, pulse reset_i for 1 cycle -> all valids 0, counters 0, readies 1 on the next cycle, no stale output.
